// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipeline.
// Covers the hazards that bypassing cannot resolve:
// - a load-use bubble,
// - a younger-instruction flush on a branch taken in MEM,
// - a pipeline freeze through the data-memory request/ack handshake,
//   with a timeout error and saturating perf counters.
module hazard_stall_unit #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr_reg,
  input  logic [31:0]      instr_reg_ex,
  input  logic [31:0]      instr_reg_mem,
  input  logic             RegWrite_exe,
  input  logic             branch_taken_mem,
  input  logic             dmem_ack,
  input  logic             clr_counters,
  output logic             dmem_req,
  output logic             pipe_freeze,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             memwb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_e;

  // Last wait count value before the freeze total reaches MEM_TIMEOUT.
  localparam logic [TO_W-1:0]  LAST_WAIT = TO_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e           state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  // ---------------------------------------------------------------------------
  // Instruction decode
  // ---------------------------------------------------------------------------
  function automatic logic is_ldur(input logic [31:0] i);
    return i[31:21] == 11'b11111000010;
  endfunction

  function automatic logic is_stur(input logic [31:0] i);
    return i[31:21] == 11'b11111000000;
  endfunction

  function automatic logic is_rtype(input logic [31:0] i);
    return (i[31:21] == 11'b10001011000) || (i[31:21] == 11'b10101011000) ||
           (i[31:21] == 11'b11001011000) || (i[31:21] == 11'b11101011000) ||
           (i[31:21] == 11'b10001010000) || (i[31:21] == 11'b11001010000);
  endfunction

  logic       rf_is_br, rf_is_cbz, rf_is_b, rf_is_bl;
  logic       uses_rn, uses_rm, uses_rt;
  logic [4:0] rd_ex;
  logic       load_use, mem_op, freeze;

  assign rf_is_br  = instr_reg[31:21] == 11'b11010110000;
  assign rf_is_cbz = instr_reg[31:24] == 8'b10110100;
  assign rf_is_b   = instr_reg[31:26] == 6'b000101;
  assign rf_is_bl  = instr_reg[31:26] == 6'b100101;

  // Source fields actually read by the RF-stage instruction.
  assign uses_rn = !(rf_is_b || rf_is_bl || rf_is_cbz);
  assign uses_rm = is_rtype(instr_reg);
  assign uses_rt = is_stur(instr_reg) || rf_is_cbz || rf_is_br;

  assign rd_ex = instr_reg_ex[4:0];

  // X31 is the zero register, so a load into it never creates a dependency.
  assign load_use = is_ldur(instr_reg_ex) && RegWrite_exe && (rd_ex != 5'd31) &&
                    ((uses_rn && (instr_reg[9:5]   == rd_ex)) ||
                     (uses_rm && (instr_reg[20:16] == rd_ex)) ||
                     (uses_rt && (instr_reg[4:0]   == rd_ex)));

  assign mem_op = is_ldur(instr_reg_mem) || is_stur(instr_reg_mem);

  // ---------------------------------------------------------------------------
  // Next-state and Mealy outputs: memory freeze first, then branch, then load-use
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    err_d        = err_q;
    freeze       = 1'b0;
    dmem_req     = 1'b0;
    pipe_freeze  = 1'b0;
    pc_we        = 1'b1;
    ifid_we      = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    exmem_bubble = 1'b0;
    memwb_bubble = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req = mem_op;
        if (mem_op && !dmem_ack) begin
          freeze = 1'b1;
          if (MEM_TIMEOUT <= 1) begin
            state_d = ERR;
            err_d   = 1'b1;
          end else begin
            state_d    = MEM_WAIT;
            wait_cnt_d = TO_W'(1);
          end
        end
      end
      MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          state_d    = RUN;
          wait_cnt_d = '0;
        end else begin
          freeze = 1'b1;
          if (wait_cnt_q >= LAST_WAIT) begin
            state_d    = ERR;
            err_d      = 1'b1;
            wait_cnt_d = '0;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end
      end
      ERR: begin
        freeze = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    if (freeze) begin
      pipe_freeze  = 1'b1;
      pc_we        = 1'b0;
      ifid_we      = 1'b0;
      memwb_bubble = 1'b1;
    end else if (branch_taken_mem) begin
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      exmem_bubble = 1'b1;
    end else if (load_use) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  // Saturating perf counters; a clear request beats the increment.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (clr_counters) begin
      stall_d  = '0;
      bubble_d = '0;
    end else begin
      if (!pc_we && (stall_q != CNT_MAX))       stall_d  = stall_q + CNT_W'(1);
      if (idex_bubble && (bubble_q != CNT_MAX)) bubble_d = bubble_q + CNT_W'(1);
    end
  end

  // State, wait counter, sticky error and counters with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update together at the edge.
    if (reset) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
      stall_q    <= '0;
      bubble_q   <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      bubble_q   <= bubble_d;
    end
  end

  assign mem_timeout_err = err_q;
  assign stall_cycles    = stall_q;
  assign bubble_count    = bubble_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: decode vector table, directed
// multi-cycle sequences and randomized traffic against a cycle-level reference model.
module tb_hazard_stall_unit;

  localparam int CNT_W       = 32;
  localparam int MEM_TIMEOUT = 16;
  localparam int TO_W        = 5;
  localparam int SMALL_W     = 3;

  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;

  logic clk = 1'b0;
  logic reset, RegWrite_exe, branch_taken_mem, dmem_ack, clr_counters;
  logic [31:0] instr_reg, instr_reg_ex, instr_reg_mem;

  logic dmem_req, pipe_freeze, pc_we, ifid_we, ifid_flush, idex_bubble;
  logic exmem_bubble, memwb_bubble, mem_timeout_err;
  logic [CNT_W-1:0] stall_cycles, bubble_count;

  logic s_dmem_req, s_pipe_freeze, s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble;
  logic s_exmem_bubble, s_memwb_bubble, s_mem_timeout_err;
  logic [SMALL_W-1:0] s_stall_cycles, s_bubble_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut (
    .clk(clk), .reset(reset), .instr_reg(instr_reg), .instr_reg_ex(instr_reg_ex),
    .instr_reg_mem(instr_reg_mem), .RegWrite_exe(RegWrite_exe),
    .branch_taken_mem(branch_taken_mem), .dmem_ack(dmem_ack), .clr_counters(clr_counters),
    .dmem_req(dmem_req), .pipe_freeze(pipe_freeze), .pc_we(pc_we), .ifid_we(ifid_we),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .exmem_bubble(exmem_bubble),
    .memwb_bubble(memwb_bubble), .mem_timeout_err(mem_timeout_err),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  hazard_stall_unit #(.CNT_W(SMALL_W), .MEM_TIMEOUT(MEM_TIMEOUT), .TO_W(TO_W)) dut_s (
    .clk(clk), .reset(reset), .instr_reg(instr_reg), .instr_reg_ex(instr_reg_ex),
    .instr_reg_mem(instr_reg_mem), .RegWrite_exe(RegWrite_exe),
    .branch_taken_mem(branch_taken_mem), .dmem_ack(dmem_ack), .clr_counters(clr_counters),
    .dmem_req(s_dmem_req), .pipe_freeze(s_pipe_freeze), .pc_we(s_pc_we), .ifid_we(s_ifid_we),
    .ifid_flush(s_ifid_flush), .idex_bubble(s_idex_bubble), .exmem_bubble(s_exmem_bubble),
    .memwb_bubble(s_memwb_bubble), .mem_timeout_err(s_mem_timeout_err),
    .stall_cycles(s_stall_cycles), .bubble_count(s_bubble_count)
  );

  // Output vector order: req, freeze, pc_we, ifid_we, flush, idex, exmem, memwb, err
  logic [8:0] dut_o, dut_s_o;
  assign dut_o   = {dmem_req, pipe_freeze, pc_we, ifid_we, ifid_flush, idex_bubble,
                    exmem_bubble, memwb_bubble, mem_timeout_err};
  assign dut_s_o = {s_dmem_req, s_pipe_freeze, s_pc_we, s_ifid_we, s_ifid_flush, s_idex_bubble,
                    s_exmem_bubble, s_memwb_bubble, s_mem_timeout_err};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Instruction builders
  // ---------------------------------------------------------------------------
  function automatic logic [31:0] mk(input logic [10:0] op, input logic [4:0] rm,
                                     input logic [4:0] rn, input logic [4:0] rt);
    return {op, rm, 6'b000000, rn, rt};
  endfunction

  function automatic logic [31:0] mk_b(input logic [5:0] op, input logic [4:0] f95);
    return {op, 16'h0000, f95, 5'd0};
  endfunction

  function automatic logic [31:0] mk_cbz(input logic [4:0] f95, input logic [4:0] rt);
    return {8'b10110100, 14'h0000, f95, rt};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  bit     m_err;
  int     m_wait;      // freeze cycles spent on the outstanding access so far
  longint m_stall, m_bub, m_stall_s, m_bub_s;

  function automatic bit hazard(input logic [31:0] ex, input logic [31:0] rf, input bit rw);
    logic [4:0] d;
    logic [10:0] op;
    bit no_rn, rtype, rt_used;
    d = ex[4:0];
    op = rf[31:21];
    no_rn   = (rf[31:26] == 6'b000101) || (rf[31:26] == 6'b100101) || (rf[31:24] == 8'b10110100);
    rtype   = (op == OP_ADD) || (op == OP_ADDS) || (op == OP_SUB) || (op == OP_SUBS) ||
              (op == OP_AND) || (op == OP_EOR);
    rt_used = (op == OP_STUR) || (rf[31:24] == 8'b10110100) || (op == OP_BR);
    if (ex[31:21] != OP_LDUR || !rw || d == 5'd31) return 1'b0;
    return (!no_rn && rf[9:5] == d) || (rtype && rf[20:16] == d) || (rt_used && rf[4:0] == d);
  endfunction

  function automatic logic [8:0] model_outputs();
    bit req;
    if (m_err) return 9'b0_1_0_0_0_0_0_1_1;
    req = (m_wait > 0) || (instr_reg_mem[31:21] == OP_LDUR) || (instr_reg_mem[31:21] == OP_STUR);
    if (req && !dmem_ack)  return {1'b1, 8'b1_0_0_0_0_0_1_0};
    if (branch_taken_mem)  return {req,  8'b0_1_1_1_1_1_0_0};
    if (hazard(instr_reg_ex, instr_reg, RegWrite_exe)) return {req, 8'b0_0_0_0_1_0_0_0};
    return {req, 8'b0_1_1_0_0_0_0_0};
  endfunction

  function automatic longint sat(input longint v, input bit inc, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    if (clr_counters) return 0;
    if (inc && v < mx) return v + 1;
    return v;
  endfunction

  function automatic void model_update(input logic [8:0] e);
    if (reset) begin
      m_err = 0; m_wait = 0; m_stall = 0; m_bub = 0; m_stall_s = 0; m_bub_s = 0;
      return;
    end
    m_stall   = sat(m_stall,   !e[6], CNT_W);
    m_bub     = sat(m_bub,      e[3], CNT_W);
    m_stall_s = sat(m_stall_s, !e[6], SMALL_W);
    m_bub_s   = sat(m_bub_s,    e[3], SMALL_W);
    if (!m_err) begin
      if (e[7]) begin
        m_wait++;
        if (m_wait >= MEM_TIMEOUT) begin
          m_err  = 1;
          m_wait = 0;
        end
      end else begin
        m_wait = 0;
      end
    end
  endfunction

  // One clock cycle: compare against the model mid-cycle, then advance the model.
  task automatic step(input string tag);
    logic [8:0] e;
    @(negedge clk);
    e = model_outputs();
    check({tag, " outs"},    64'(dut_o),          64'(e));
    check({tag, " outs_s"},  64'(dut_s_o),        64'(e));
    check({tag, " stall"},   64'(stall_cycles),   m_stall);
    check({tag, " bubbles"}, 64'(bubble_count),   m_bub);
    check({tag, " stall_s"}, 64'(s_stall_cycles), m_stall_s);
    check({tag, " bub_s"},   64'(s_bubble_count), m_bub_s);
    @(posedge clk);
    model_update(e);
    #1;
  endtask

  task automatic idle_inputs();
    instr_reg = '0; instr_reg_ex = '0; instr_reg_mem = '0;
    RegWrite_exe = 1'b0; branch_taken_mem = 1'b0; dmem_ack = 1'b0; clr_counters = 1'b0;
  endtask

  function automatic logic [4:0] rreg();
    int r;
    r = $urandom_range(0, 4);
    return (r == 4) ? 5'd31 : 5'(r);
  endfunction

  function automatic logic [31:0] rnd_instr();
    case ($urandom_range(0, 11))
      0:  return mk(OP_LDUR, rreg(), rreg(), rreg());
      1:  return mk(OP_STUR, rreg(), rreg(), rreg());
      2:  return mk(OP_BR,   rreg(), rreg(), rreg());
      3:  return mk_cbz(rreg(), rreg());
      4:  return mk_b(6'b000101, rreg());
      5:  return mk_b(6'b100101, rreg());
      6:  return mk(OP_ADD,  rreg(), rreg(), rreg());
      7:  return mk(OP_SUBS, rreg(), rreg(), rreg());
      8:  return mk(OP_AND,  rreg(), rreg(), rreg());
      9:  return mk(OP_EOR,  rreg(), rreg(), rreg());
      10: return mk(OP_ADDS, rreg(), rreg(), rreg());
      default: return {$urandom_range(0, 2047), 21'h0} | 32'(rreg()) << 5;
    endcase
  endfunction

  typedef struct {
    logic [31:0] ex;
    logic [31:0] rf;
    logic        rw;
    logic        stall;
  } vec_t;

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd1),  mk(OP_ADD, 5'd3, 5'd1, 5'd2),  1'b1, 1'b1};
    tbl[1]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd1),  mk(OP_ADD, 5'd1, 5'd3, 5'd2),  1'b1, 1'b1};
    tbl[2]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd1),  mk(OP_ADD, 5'd4, 5'd3, 5'd1),  1'b1, 1'b0};
    tbl[3]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd31), mk(OP_ADD, 5'd3, 5'd31, 5'd2), 1'b1, 1'b0};
    tbl[4]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd5),  mk_b(6'b000101, 5'd5),         1'b1, 1'b0};
    tbl[5]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd5),  mk_cbz(5'd0, 5'd5),            1'b1, 1'b1};
    tbl[6]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd5),  mk_cbz(5'd5, 5'd4),            1'b1, 1'b0};
    tbl[7]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd7),  mk(OP_STUR, 5'd0, 5'd2, 5'd7), 1'b1, 1'b1};
    tbl[8]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd7),  mk(OP_STUR, 5'd0, 5'd7, 5'd2), 1'b1, 1'b1};
    tbl[9]  = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd7),  mk(OP_ADD, 5'd3, 5'd7, 5'd2),  1'b0, 1'b0};
    tbl[10] = '{mk(OP_STUR, 5'd0, 5'd2, 5'd1),  mk(OP_ADD, 5'd3, 5'd1, 5'd2),  1'b1, 1'b0};
    tbl[11] = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd9),  mk(OP_LDUR, 5'd9, 5'd3, 5'd4), 1'b1, 1'b0};
    tbl[12] = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd3),  mk(OP_BR, 5'd0, 5'd3, 5'd0),   1'b1, 1'b1};
    tbl[13] = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd4),  mk(OP_BR, 5'd0, 5'd0, 5'd4),   1'b1, 1'b1};
    tbl[14] = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd6),  mk(OP_EOR, 5'd6, 5'd1, 5'd2),  1'b1, 1'b1};
    tbl[15] = '{mk(OP_LDUR, 5'd0, 5'd2, 5'd6),  mk_b(6'b100101, 5'd6),         1'b1, 1'b0};

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    m_err = 0; m_wait = 0; m_stall = 0; m_bub = 0; m_stall_s = 0; m_bub_s = 0;
    reset = 1'b0;
    step("reset_state");

    // Load-use on Rn, then the bubble in EX clears the hazard.
    instr_reg_ex = mk(OP_LDUR, 5'd0, 5'd2, 5'd1); RegWrite_exe = 1'b1;
    instr_reg    = mk(OP_ADD, 5'd3, 5'd1, 5'd2);
    step("lu_stall");
    instr_reg_ex = '0;
    step("lu_after");
    check("lu stall_cycles", 64'(stall_cycles), 64'd1);
    check("lu bubble_count", 64'(bubble_count), 64'd1);

    // Decode vector table.
    foreach (tbl[i]) begin
      idle_inputs();
      instr_reg_ex = tbl[i].ex; instr_reg = tbl[i].rf; RegWrite_exe = tbl[i].rw;
      #2;
      check($sformatf("tbl%0d idex_bubble", i), 64'(idex_bubble), 64'(tbl[i].stall));
      check($sformatf("tbl%0d pc_we", i),       64'(pc_we),       64'(!tbl[i].stall));
      step($sformatf("tbl%0d", i));
    end

    // Memory wait: three unacked cycles, ack on the fourth.
    begin
      longint base;
      idle_inputs();
      base = m_stall;
      instr_reg_mem = mk(OP_STUR, 5'd0, 5'd2, 5'd3);
      repeat (3) step("memwait_frz");
      dmem_ack = 1'b1;
      step("memwait_ack");
      instr_reg_mem = '0; dmem_ack = 1'b0;
      step("memwait_run");
      check("memwait stall delta", 64'(stall_cycles), base + 3);
    end

    // Branch beats load-use.
    begin
      longint base;
      base = m_bub;
      instr_reg_ex = mk(OP_LDUR, 5'd0, 5'd2, 5'd1); RegWrite_exe = 1'b1;
      instr_reg    = mk(OP_ADD, 5'd3, 5'd1, 5'd2);
      branch_taken_mem = 1'b1;
      #2;
      check("br flush",  64'({ifid_flush, idex_bubble, exmem_bubble, pc_we, ifid_we}), 64'h1F);
      step("br_lu");
      check("br bubble delta", 64'(bubble_count), base + 1);
      // Freeze defers branch and load-use until the ack cycle.
      instr_reg_mem = mk(OP_STUR, 5'd0, 5'd2, 5'd3);
      step("br_frz");
      dmem_ack = 1'b1;
      step("br_ack");
      idle_inputs();
      step("br_done");
    end

    // Counter clear during a load-use stall.
    instr_reg_ex = mk(OP_LDUR, 5'd0, 5'd2, 5'd1); RegWrite_exe = 1'b1;
    instr_reg    = mk(OP_ADD, 5'd3, 5'd1, 5'd2);
    clr_counters = 1'b1;
    step("clr_lu");
    check("clr stall_cycles", 64'(stall_cycles), 64'd0);
    check("clr bubble_count", 64'(bubble_count), 64'd0);
    idle_inputs();
    step("clr_after");

    // Timeout: LDUR in MEM with no ack ever.
    instr_reg_mem = mk(OP_LDUR, 5'd0, 5'd2, 5'd3);
    for (int k = 0; k < MEM_TIMEOUT; k++) begin
      #2;
      check($sformatf("to frz%0d", k), 64'({pipe_freeze, dmem_req, mem_timeout_err}), 64'b110);
      step("to_frz");
    end
    #2;
    check("to err state", 64'({mem_timeout_err, dmem_req, pipe_freeze}), 64'b101);
    check("to small sat", 64'(s_stall_cycles), 64'd7);
    repeat (3) step("to_err");
    check("to small sat hold", 64'(s_stall_cycles), 64'd7);
    reset = 1'b1;
    step("to_reset");
    reset = 1'b0;
    #2;
    check("to rerun", 64'({mem_timeout_err, dmem_req}), 64'b01);
    step("to_rerun");
    dmem_ack = 1'b1;
    step("to_ack");
    idle_inputs();

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      instr_reg        = rnd_instr();
      instr_reg_ex     = ($urandom_range(0, 1) == 0) ? mk(OP_LDUR, 5'd0, rreg(), rreg()) : rnd_instr();
      instr_reg_mem    = rnd_instr();
      RegWrite_exe     = ($urandom_range(0, 3) != 0);
      branch_taken_mem = ($urandom_range(0, 7) == 0);
      dmem_ack         = ($urandom_range(0, 2) != 0);
      clr_counters     = ($urandom_range(0, 31) == 0);
      reset            = ($urandom_range(0, 99) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
